// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding and block geometry for the burst responder.
package mem_bus_pkg;
  localparam int BEATS_PER_BLOCK = 4;
  localparam int WORD_BITS = 32;
  typedef enum logic [1:0] {IDLE, WAIT, BEAT, DONE} memresp_state_t;
endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: single-port backing store, asynchronous read and synchronous write.
module mem_word_array
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [WORD_BITS-1:0] wdata_i,
  output logic [WORD_BITS-1:0] rdata_o
);
  logic [WORD_BITS-1:0] mem_q [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_burst_responder.sv
// mem_burst_responder: 4-beat block read/writeback responder with programmable wait states.
// Defining MEMRESP_RANGECHECK_EN adds HError for blocks beyond DEPTH_WORDS; otherwise addresses wrap.
module mem_burst_responder
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemRE,
  input  logic                 HWriteM,
  input  logic [31:0]          HAddr,
  input  logic [WORD_BITS-1:0] HWData,
  output logic [WORD_BITS-1:0] HRData,
  output logic                 BusReady,
`ifdef MEMRESP_RANGECHECK_EN
  output logic                 Busy,
  output logic                 HError
`else
  output logic                 Busy
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);
  memresp_state_t state_q, state_d;
  logic [27:0] base_q, base_d;
  logic [1:0] beat_q, beat_d;
  logic [3:0] wait_q, wait_d;
  logic wr_q, wr_d, ready_q, busy_q;
  logic req, range_err, we, unused_ok;
  logic [29:0] word;
  logic [WORD_BITS-1:0] rdata;
  assign req = MemRE | HWriteM;
  assign word = {base_q, beat_q};
`ifdef MEMRESP_RANGECHECK_EN
  assign range_err = |word[29:AW];
  assign HError = ready_q & range_err;
`else
  assign range_err = 1'b0;
`endif
  assign unused_ok = ^{HAddr[3:0], word[29:AW]};
  // Dropping both requests during a beat aborts it, so the write is gated by req as well.
  assign we = (state_q == BEAT) && wr_q && req && !range_err;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    wr_d = wr_q;
    beat_d = beat_q;
    wait_d = wait_q;
    case (state_q)
      IDLE: if (req) begin
        base_d = HAddr[31:4];
        wr_d = HWriteM;
        beat_d = '0;
        wait_d = LAT;
        state_d = (LAT == 4'd0) ? BEAT : WAIT;
      end
      WAIT: if (!req) state_d = IDLE;
        else begin
          wait_d = wait_q - 4'd1;
          state_d = (wait_q == 4'd1) ? BEAT : WAIT;
        end
      BEAT: if (!req) state_d = IDLE;
        else if (beat_q == 2'(BEATS_PER_BLOCK - 1)) state_d = DONE;
        else begin
          beat_d = beat_q + 2'd1;
          wait_d = LAT;
          state_d = (LAT == 4'd0) ? BEAT : WAIT;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      base_q <= '0;
      wr_q <= 1'b0;
      beat_q <= '0;
      wait_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      wr_q <= wr_d;
      beat_q <= beat_d;
      wait_q <= wait_d;
      ready_q <= state_d == BEAT;
      busy_q <= state_d != IDLE;
    end
  mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_store (
    .clk(clk),
    .we_i(we),
    .addr_i(word[AW-1:0]),
    .wdata_i(HWData),
    .rdata_o(rdata)
  );
  assign HRData = (ready_q && !wr_q && !range_err) ? rdata : '0;
  assign BusReady = ready_q;
  assign Busy = busy_q;
endmodule

// File: tb/tb_mem_burst_responder.sv
// tb_mem_burst_responder: random-stimulus bench for two responders (LATENCY 2 and 0) against a word-array model.
module tb_mem_burst_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic re [2];
  logic wm [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic rdy [2];
  logic busy [2];
`ifdef MEMRESP_RANGECHECK_EN
  logic herr [2];
`endif
  logic [31:0] mdl [2][1024];
  bit known [2][1024];
  logic [31:0] dat [4];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_burst_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(rst_n), .MemRE(re[0]), .HWriteM(wm[0]), .HAddr(addr[0]),
    .HWData(wd[0]), .HRData(rd[0]), .BusReady(rdy[0]),
`ifdef MEMRESP_RANGECHECK_EN
    .Busy(busy[0]), .HError(herr[0])
`else
    .Busy(busy[0])
`endif
  );

  mem_burst_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(rst_n), .MemRE(re[1]), .HWriteM(wm[1]), .HAddr(addr[1]),
    .HWData(wd[1]), .HRData(rd[1]), .BusReady(rdy[1]),
`ifdef MEMRESP_RANGECHECK_EN
    .Busy(busy[1]), .HError(herr[1])
`else
    .Busy(busy[1])
`endif
  );

  // Called at a falling edge with the selected DUT idle; returns at a falling edge in its next idle cycle.
  task automatic run_burst(input int sel, input bit wr, input bit both, input logic [31:0] a,
                           input int abort_k, input bit hold, input logic [31:0] d [4]);
    int n, last, beat, idx;
    logic [31:0] base, exp_rd;
    bit err, exp_rdy, exp_busy;
    n = (sel == 0) ? 3 : 1;
    last = 4 * n;
    base = a >> 4;
    err = 1'b0;
`ifdef MEMRESP_RANGECHECK_EN
    err = (base * 4) >= 1024;
`endif
    wm[sel] = wr;
    re[sel] = !wr || both;
    addr[sel] = a;
    wd[sel] = $urandom;
    for (int k = 1; k <= last + 2; k++) begin
      @(negedge clk);
      if (abort_k > 0 && k == abort_k + 1) begin
        total++;
        if (busy[sel] !== 1'b0 || rdy[sel] !== 1'b0 || rd[sel] !== 32'h0) begin
          bad++;
          $display("FAIL abort_idle sel=%0d k=%0d busy=%b rdy=%b rd=%h want 0 0 0", sel, k, busy[sel], rdy[sel], rd[sel]);
        end
        break;
      end
      exp_rdy = (k % n == 0) && (k <= last);
      exp_busy = k <= last + 1;
      beat = exp_rdy ? k / n - 1 : 0;
      idx = int'((base * 4 + 32'(beat)) % 1024);
      total++;
      if (rdy[sel] !== exp_rdy) begin
        bad++;
        $display("FAIL busready sel=%0d a=%h k=%0d got=%b want=%b", sel, a, k, rdy[sel], exp_rdy);
      end
      total++;
      if (busy[sel] !== exp_busy) begin
        bad++;
        $display("FAIL busy sel=%0d a=%h k=%0d got=%b want=%b", sel, a, k, busy[sel], exp_busy);
      end
      if (!exp_rdy || (!wr && (err || known[sel][idx]))) begin
        exp_rd = (!exp_rdy || err) ? 32'h0 : mdl[sel][idx];
        total++;
        if (rd[sel] !== exp_rd) begin
          bad++;
          $display("FAIL hrdata sel=%0d a=%h k=%0d got=%h want=%h", sel, a, k, rd[sel], exp_rd);
        end
      end
`ifdef MEMRESP_RANGECHECK_EN
      total++;
      if (herr[sel] !== (exp_rdy && err)) begin
        bad++;
        $display("FAIL herror sel=%0d a=%h k=%0d got=%b want=%b", sel, a, k, herr[sel], exp_rdy && err);
      end
`endif
      if (exp_rdy && wr) begin
        wd[sel] = d[beat];
        if (k != abort_k && !err) begin
          mdl[sel][idx] = d[beat];
          known[sel][idx] = 1'b1;
        end
      end
      if (k == abort_k) begin
        re[sel] = 1'b0;
        wm[sel] = 1'b0;
      end else if (k == last + 1) begin
        wm[sel] = 1'b0;
        re[sel] = hold;
      end else if (k <= last) begin
        addr[sel] = $urandom;
        if (wr) re[sel] = 1'($urandom_range(0, 1));
        else wm[sel] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic rand_dat();
    for (int i = 0; i < 4; i++) dat[i] = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      re[s] = 1'b0; wm[s] = 1'b0; addr[s] = '0; wd[s] = '0;
    end
    #1;
    for (int s = 0; s < 2; s++) begin
      total++;
      if (busy[s] !== 1'b0 || rdy[s] !== 1'b0 || rd[s] !== 32'h0) begin
        bad++;
        $display("FAIL reset_state sel=%0d busy=%b rdy=%b rd=%h want 0 0 0", s, busy[s], rdy[s], rd[s]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_latency2();
    dat = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_burst(0, 1'b1, 1'b0, 32'h100, 0, 1'b0, dat);
    run_burst(0, 1'b0, 1'b0, 32'h100, 0, 1'b0, dat);
  endtask

  task automatic test_write_latency0();
    dat = '{32'd11, 32'd22, 32'd33, 32'd44};
    run_burst(1, 1'b1, 1'b0, 32'h200, 0, 1'b0, dat);
    run_burst(1, 1'b0, 1'b0, 32'h200, 0, 1'b0, dat);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      rand_dat();
      run_burst(s, 1'b1, 1'b0, 32'h300, 0, 1'b1, dat);
      run_burst(s, 1'b0, 1'b0, 32'h300, 0, 1'b0, dat);
    end
  endtask

  task automatic test_abort();
    run_burst(0, 1'b0, 1'b0, 32'h100, 4, 1'b0, dat);
    rand_dat();
    run_burst(1, 1'b1, 1'b0, 32'h500, 0, 1'b0, dat);
    rand_dat();
    run_burst(1, 1'b1, 1'b0, 32'h500, 3, 1'b0, dat);
    run_burst(1, 1'b0, 1'b0, 32'h500, 0, 1'b0, dat);
  endtask

  task automatic test_reset_mid_burst();
    re[0] = 1'b1;
    addr[0] = 32'h100;
    @(negedge clk);
    total++;
    if (busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL busy_before_reset got=%b want=1", busy[0]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy[0] !== 1'b0 || rdy[0] !== 1'b0 || rd[0] !== 32'h0) begin
      bad++;
      $display("FAIL async_reset busy=%b rdy=%b rd=%h want 0 0 0", busy[0], rdy[0], rd[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    re[0] = 1'b0;
    @(negedge clk);
    total++;
    if (busy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      bad++;
      $display("FAIL after_reset busy=%b rdy=%b want 0 0", busy[0], rdy[0]);
    end
    run_burst(0, 1'b0, 1'b0, 32'h100, 0, 1'b0, dat);
  endtask

  task automatic test_priority_and_range();
    rand_dat();
    run_burst(1, 1'b1, 1'b1, 32'h640, 0, 1'b0, dat);
    run_burst(1, 1'b0, 1'b0, 32'h640, 0, 1'b0, dat);
    rand_dat();
    run_burst(0, 1'b1, 1'b0, 32'h000, 0, 1'b0, dat);
    rand_dat();
    run_burst(0, 1'b1, 1'b1, 32'h4000, 0, 1'b0, dat);
    run_burst(0, 1'b0, 1'b0, 32'h4000, 0, 1'b0, dat);
    run_burst(0, 1'b0, 1'b0, 32'h000, 0, 1'b0, dat);
  endtask

  task automatic test_random();
    int s;
    bit wr;
    for (int i = 0; i < 24; i++) begin
      s = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      rand_dat();
      run_burst(s, wr, 1'($urandom_range(0, 1)), (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15)),
                0, 1'b0, dat);
    end
  endtask

  initial begin
    test_reset();
    test_read_latency2();
    test_write_latency0();
    test_back_to_back();
    test_abort();
    test_reset_mid_burst();
    test_priority_and_range();
    test_random();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_burst_responder.md
MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, backing-store size in 32-bit words; SHALL be a power of two and at least 4.
REQ-002 Parameter LATENCY, default 2, wait cycles before each beat; SHALL accept 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 MemRE  input  1  initiator requests a 4-word block read.
REQ-006 HWriteM  input  1  initiator requests a 4-word block writeback.
REQ-007 HAddr  input  32  byte address; bits [31:4] select the block.
REQ-008 HWData  input  32  write data for the current beat.
REQ-009 HRData  output  32  read data for the current beat.
REQ-010 BusReady  output  1  one-cycle strobe marking a completed beat.
REQ-011 Busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, WAIT, BEAT and DONE.
REQ-013 IDLE with HWriteM|MemRE high SHALL latch HAddr[31:4] as base and direction (write if HWriteM), clear beat counter to 0, load wait counter with LATENCY, then go to WAIT (LATENCY>0) or BEAT (LATENCY=0).
REQ-014 HWriteM and MemRE both high in IDLE SHALL start a write burst (write priority).
REQ-015 WAIT SHALL decrement the wait counter and go to BEAT in the cycle it reaches 1.
REQ-016 BusReady SHALL be high only in BEAT (Moore output, exactly one cycle per beat).
REQ-017 Word index SHALL be {base, beat}, taken modulo DEPTH_WORDS.
REQ-018 Read burst in BEAT: HRData SHALL present the indexed word combinationally; HRData SHALL be 0 outside BEAT.
REQ-019 Write burst in BEAT: HWData SHALL be written to the indexed word at the clock edge ending BEAT.
REQ-020 After BEAT: beat<3 SHALL increment beat, reload LATENCY and go to WAIT (or BEAT again if LATENCY=0); beat=3 SHALL go to DONE.
REQ-021 DONE SHALL last exactly one cycle with BusReady low, then go to IDLE regardless of requests.
REQ-022 A request still high in IDLE after DONE SHALL start a new burst, so a writeback followed by a read is served back-to-back.
REQ-023 Both requests dropping during WAIT or BEAT SHALL abort to IDLE at the next edge without a write in that cycle; completed writes are kept.
REQ-024 HAddr and request-direction changes after the burst starts SHALL be ignored.
REQ-025 With LATENCY=2, a request sampled at edge 0 SHALL produce BusReady in cycles 3, 6, 9 and 12, DONE in cycle 13 and IDLE in cycle 14.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, beat=0, wait counter=0, BusReady=0, Busy=0 and HRData=0.
REQ-027 Reset mid-burst SHALL abandon the burst; backing-store contents are not cleared by reset.

Configuration
REQ-028 MEMRESP_RANGECHECK_EN defined SHALL add output HError (1 bit). HError is high together with BusReady when base*4 >= DEPTH_WORDS; in that case writes are suppressed and HRData is 0.
REQ-029 MEMRESP_RANGECHECK_EN undefined SHALL remove HError, and addresses SHALL wrap modulo DEPTH_WORDS.

Structure
REQ-030 Package mem_bus_pkg SHALL hold the state enum (memresp_state_t), BEATS_PER_BLOCK=4 and WORD_BITS=32.
REQ-031 The backing store SHALL be a separate sub-module, mem_word_array (async read, sync write, one port).

Verification
REQ-032 Reset, LATENCY=2, preload word 0x40..0x43 = A0..A3, MemRE with HAddr=0x100 -> BusReady in cycles 3, 6, 9, 12 with HRData A0, A1, A2, A3; Busy low at cycle 14.
REQ-033 LATENCY=0, HWriteM with HAddr=0x200 and HWData 11, 22, 33, 44 per beat -> BusReady on 4 consecutive cycles; words 0x80..0x83 hold 11, 22, 33, 44.
REQ-034 Writeback to 0x300 immediately followed by MemRE to 0x300 -> read burst starts in the cycle after DONE and returns the written data.
REQ-035 MemRE dropped after beat 1, or reset asserted during WAIT -> IDLE, BusReady low, no further store writes.
REQ-036 MemRE and HWriteM high together -> write burst; with MEMRESP_RANGECHECK_EN and HAddr=0x4000 (DEPTH=1024) -> HError high on all 4 beats, store unchanged.
